// File: rtl/rdata_chan_mngr.sv
// Manager-side R-channel receiver: packs a fixed 4-beat, 32-bit burst into one 128-bit word.
// Optional burst protocol checking (rlast position, rid consistency) is enabled by RDAT_M_LASTCHK_EN.
module rdata_chan_mngr (
    input  logic         clk,
    input  logic         rst,
    input  logic         rvalid,
    output logic         rready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic         rlast,
    output logic         rdata_m_valid,
    output logic [3:0]   rdata_m_id,
    output logic [127:0] rdata_m_data,
    output logic         rdata_m_err,
    input  logic         finish_rdata_m
);

    localparam int unsigned BEAT_W  = 32;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned WORD_W  = 128;

    typedef enum logic [1:0] {
        RDAT_MIDLE = 2'b00,
        RDAT_MRECV = 2'b01,
        RDAT_MFULL = 2'b10,
        RDAT_MDEFO = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_beat_cntr;
    logic [ID_W-1:0]     r_id;
    logic [WORD_W-1:0]   r_data;
    logic                w_accept;
    logic                w_last_beat;

    assign rready        = (r_state == RDAT_MIDLE) | (r_state == RDAT_MRECV);
    assign w_accept      = rvalid & rready;
    assign w_last_beat   = (r_beat_cntr == CNT_W'(3));
    assign rdata_m_valid = (r_state == RDAT_MFULL);
    assign rdata_m_id    = r_id;
    assign rdata_m_data  = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RDAT_MIDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Burst termination is purely count based; unknown encodings fall into the sticky trap state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            RDAT_MIDLE: if (w_accept) w_next = RDAT_MRECV;
            RDAT_MRECV: if (w_accept && w_last_beat) w_next = RDAT_MFULL;
            RDAT_MFULL: if (finish_rdata_m) w_next = RDAT_MIDLE;
            default:    w_next = RDAT_MDEFO;
        endcase
    end

    // Beat n lands in bits [32n+31:32n]; the ID is taken from beat 0 only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cntr <= '0;
            r_id        <= '0;
            r_data      <= '0;
        end else if (w_accept) begin
            if (r_state == RDAT_MIDLE) begin
                r_data[BEAT_W-1:0] <= rdata;
                r_id               <= rid;
                r_beat_cntr        <= CNT_W'(1);
            end else begin
                r_data[{r_beat_cntr, 5'd0} +: BEAT_W] <= rdata;
                r_beat_cntr                           <= r_beat_cntr + CNT_W'(1);
            end
        end
    end

`ifdef RDAT_M_LASTCHK_EN
    logic r_err_lat;

    // Sticky per-burst error; cleared on the edge that releases the assembled word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_lat <= 1'b0;
        end else if ((r_state == RDAT_MFULL) && finish_rdata_m) begin
            r_err_lat <= 1'b0;
        end else if (w_accept) begin
            if (r_state == RDAT_MIDLE) begin
                if (rlast) r_err_lat <= 1'b1;
            end else if ((rlast != w_last_beat) || (rid != r_id)) begin
                r_err_lat <= 1'b1;
            end
        end
    end

    assign rdata_m_err = r_err_lat;
`else
    logic w_unused;

    assign w_unused    = &{1'b0, rlast};
    assign rdata_m_err = 1'b0;
`endif

endmodule

// File: tb/tb_rdata_chan_mngr.sv
// Directed bench for rdata_chan_mngr; expected words are queued when a burst is driven and
// compared when the DUT presents rdata_m_valid.
module tb_rdata_chan_mngr;

    logic         clk = 1'b0;
    logic         rst;
    logic         rvalid;
    logic         rready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic         rlast;
    logic         rdata_m_valid;
    logic [3:0]   rdata_m_id;
    logic [127:0] rdata_m_data;
    logic         rdata_m_err;
    logic         finish_rdata_m;

`ifdef RDAT_M_LASTCHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]   id;
        logic [127:0] data;
        logic         err;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   checks   = 0;
    int   failures = 0;

    rdata_chan_mngr dut (
        .clk            (clk),
        .rst            (rst),
        .rvalid         (rvalid),
        .rready         (rready),
        .rid            (rid),
        .rdata          (rdata),
        .rlast          (rlast),
        .rdata_m_valid  (rdata_m_valid),
        .rdata_m_id     (rdata_m_id),
        .rdata_m_data   (rdata_m_data),
        .rdata_m_err    (rdata_m_err),
        .finish_rdata_m (finish_rdata_m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat at a negedge, wait (bounded) for rready, return at the negedge after acceptance.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] id, input logic last);
        int n;
        n      = 0;
        rvalid = 1'b1;
        rdata  = d;
        rid    = id;
        rlast  = last;
        while (!rready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("beat_wait", 128'(n < 50), 128'(1));
        @(negedge clk);
    endtask

    task automatic send_burst(input logic [3:0] id, input logic [127:0] word, input int last_pos,
                              input logic exp_err, input bit gap, input bit drop_rvalid);
        exp_t e;
        e.id   = id;
        e.data = word;
        e.err  = exp_err;
        sb.push_back(e);
        for (int i = 0; i < 4; i++) begin
            send_beat(word[32*i +: 32], id, (i == last_pos));
            if (i == 2) chk("valid_before_beat3", 128'(rdata_m_valid), 128'(0));
            if (gap && i == 1) begin
                rvalid = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    chk("gap_rready", 128'(rready), 128'(1));
                    @(negedge clk);
                end
            end
        end
        if (drop_rvalid) rvalid = 1'b0;
    endtask

    task automatic check_out();
        chk("out_valid", 128'(rdata_m_valid), 128'(1));
        chk("out_rready_low", 128'(rready), 128'(0));
        if (sb.size() == 0) begin
            chk("sb_nonempty", 128'(0), 128'(1));
        end else begin
            last_exp = sb.pop_front();
            chk("out_data", rdata_m_data, last_exp.data);
            chk("out_id", 128'(rdata_m_id), 128'(last_exp.id));
            chk("out_err", 128'(rdata_m_err), 128'(last_exp.err));
        end
    endtask

    task automatic finish_pulse();
        finish_rdata_m = 1'b1;
        @(negedge clk);
        finish_rdata_m = 1'b0;
        chk("post_finish_valid", 128'(rdata_m_valid), 128'(0));
        chk("post_finish_rready", 128'(rready), 128'(1));
        chk("post_finish_err", 128'(rdata_m_err), 128'(0));
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_rready", 128'(rready), 128'(1));
        chk("rst_valid", 128'(rdata_m_valid), 128'(0));
        chk("rst_data", rdata_m_data, 128'(0));
        chk("rst_id", 128'(rdata_m_id), 128'(0));
        chk("rst_err", 128'(rdata_m_err), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rready", 128'(rready), 128'(1));
        chk("post_rst_valid", 128'(rdata_m_valid), 128'(0));
        chk("post_rst_data", rdata_m_data, 128'(0));
    endtask

    initial begin
        rst            = 1'b1;
        rvalid         = 1'b0;
        rid            = 4'h0;
        rdata          = 32'h0;
        rlast          = 1'b0;
        finish_rdata_m = 1'b0;
        repeat (2) @(negedge clk);
        chk("init_rready", 128'(rready), 128'(1));
        chk("init_valid", 128'(rdata_m_valid), 128'(0));
        chk("init_data", rdata_m_data, 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back burst; valid must appear the cycle after beat 3.
        send_burst(4'h5, 128'h44444444_33333333_22222222_11111111, 3, 1'b0, 1'b0, 1'b1);
        check_out();
        finish_pulse();

        // Reset mid-simulation with a previously delivered word still in the register.
        do_reset();

        // Stall of 3 cycles between beats 1 and 2.
        send_burst(4'h5, 128'h44444444_33333333_22222222_11111111, 3, 1'b0, 1'b1, 1'b1);
        check_out();
        finish_pulse();

        // Consumer withholds finish while the next burst's beat 0 waits on the bus.
        send_burst(4'hA, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, 3, 1'b0, 1'b0, 1'b1);
        check_out();
        rvalid = 1'b1;
        rdata  = 32'h0BAD0000;
        rid    = 4'h3;
        rlast  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("hold_rready", 128'(rready), 128'(0));
            chk("hold_valid", 128'(rdata_m_valid), 128'(1));
            chk("hold_data", rdata_m_data, last_exp.data);
            chk("hold_id", 128'(rdata_m_id), 128'(last_exp.id));
            @(negedge clk);
        end
        finish_pulse();
        send_burst(4'h3, 128'h0BAD0003_0BAD0002_0BAD0001_0BAD0000, 3, 1'b0, 1'b0, 1'b1);
        check_out();
        finish_pulse();

        // rlast asserted early on beat 1.
        send_burst(4'h7, 128'h76543210_FEDCBA98_0F0F0F0F_A5A5A5A5, 1, CHK_EN, 1'b0, 1'b1);
        check_out();
        finish_pulse();

        // Two beats, then reset; only the fresh burst may appear.
        send_beat(32'hDEAD0000, 4'h9, 1'b0);
        send_beat(32'hDEAD0001, 4'h9, 1'b0);
        rvalid = 1'b0;
        do_reset();
        send_burst(4'hC, 128'h40000004_30000003_20000002_10000001, 3, 1'b0, 1'b0, 1'b1);
        check_out();
        finish_pulse();

        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
